jtcop_nexmap: RTL and testbench
===============================

JTCOP_NEXMAP -- requirements
Module: jtcop_nexmap

Interface
REQ-001 Parameters SHALL be (name, default, meaning): MAPW, 2, map counter width; NMAP, 4, map count before wrap (2..2^MAPW); STEP, 1, region rotation per map step (0..7); UPREG, 2, region index whose read counts up; CLRREG, 5, region index whose write clears; TOUT, 127, IRQ auto-clear delay in clocks (1..255).
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 system clock; rstn in 1 asynchronous active-low reset; ASn in 1 CPU address strobe, active low; RnW in 1 CPU read/not-write; win_cs in 1 decoded hit on the remappable window; A in 3 CPU address bits [15:13]; LVBL in 1 vertical blank, active low; iack in 1 CPU interrupt acknowledge strobe; reg_cs out 8 one-hot remapped region select; mapsel out MAPW active map index; cnt_up out 1 count-up access; cnt_clr out 1 clear access; vint_clr out 1 IRQ clear pulse; obj_copy out 1 object-copy pulse.
REQ-003 Reset SHALL be asynchronous and active-low on rstn; all registers use the single clock clk.

Function
REQ-004 cnt_up SHALL be combinational: !ASn & win_cs & RnW & A==UPREG; cnt_clr SHALL be !ASn & win_cs & !RnW & A==CLRREG.
REQ-005 A pending counter premap SHALL increment once per rising edge of cnt_up, detected against a registered copy of cnt_up.
REQ-006 premap SHALL wrap from NMAP-1 to 0 on increment.
REQ-007 A rising edge of cnt_clr SHALL set premap to 0; clear SHALL win over simultaneous count-up.
REQ-008 mapsel SHALL load premap on every clock where ASn is high, and hold while ASn is low, so the map never changes within a bus cycle.
REQ-009 reg_cs SHALL be combinational: all zero unless !ASn & win_cs; otherwise only bit ((A + mapsel*STEP) mod 8) set, using 3-bit wrap-around arithmetic.
REQ-010 reg_cs SHALL stay asserted during count-up and clear accesses; the count-up and clear access decodes do not suppress it.
REQ-011 An IRQ timer SHALL load TOUT on the clock after a LVBL falling edge, detected against a registered LVBL, reloading even if already running.
REQ-012 The timer SHALL decrement by 1 per clock while nonzero and saturate at 0.
REQ-013 vint_clr SHALL be a registered one-cycle pulse, asserted the cycle after timer==1 or the cycle after iack high; if both coincide, a single pulse.
REQ-014 iack SHALL also force the timer to 0, cancelling the pending auto-clear.
REQ-015 obj_copy SHALL be a registered one-cycle pulse, asserted the cycle after a LVBL falling edge is detected.

Reset
REQ-016 During rstn low: premap=0, mapsel=0, edge registers=0, LVBL register=1, timer=0, vint_clr=0, obj_copy=0; reg_cs follows REQ-009 with mapsel=0.
REQ-017 After reset release, no vint_clr or obj_copy pulse SHALL occur without a fresh LVBL falling edge or iack.
REQ-018 Reset asserted mid bus cycle SHALL return mapsel to 0 immediately, regardless of ASn.

Structure
REQ-019 Default parameter values and the UPREG/CLRREG region codes SHALL live in the shared package jtcop_pkg.
REQ-020 The IRQ timer (REQ-011..014) SHALL be the sub-module jtcop_irqtimer, parametrised by TOUT.
REQ-021 Target size SHALL be 120-400 lines of RTL with no memories.

Verification
REQ-022 Defaults; three reads at A=2 with ASn toggling between them, then ASn high -> mapsel=3; a read at A=0 -> reg_cs=8'h08.
REQ-023 Defaults; four count-up reads -> mapsel wraps to 0. NMAP=3, MAPW=2: three reads -> mapsel=0.
REQ-024 premap=1 before the cycle; count-up read while ASn low held 10 clocks -> mapsel stays 1 until ASn rises, then 2; a write at A=5 -> mapsel=0 after the next ASn high.
REQ-025 STEP=3, mapsel=3, access at A=7 -> reg_cs=8'h01 (wrap: 7+9=16 mod 8=0).
REQ-026 LVBL falls at cycle 0 -> obj_copy pulse at cycle 2; vint_clr single pulse at cycle TOUT+2. Second LVBL fall at cycle 50 -> vint_clr moves to cycle 50+TOUT+2.
REQ-027 iack at cycle 20 after LVBL fall -> vint_clr at cycle 21 only, no later pulse. rstn low mid-timer -> no pulse after release.

Source files
------------

// File: rtl/jtcop_pkg.sv
// Shared defaults and region codes for the CPU window remapper.
// Also holds the one-hot helper used for region decode.
package jtcop_pkg;
  localparam int MAPW_DEF = 2;
  localparam int NMAP_DEF = 4;
  localparam int STEP_DEF = 1;
  localparam int TOUT_DEF = 127;

  localparam int UPREG_DEF  = 2;
  localparam int CLRREG_DEF = 5;

  function automatic logic [7:0] onehot8(input logic [2:0] i);
    return 8'b1 << i;
  endfunction
endpackage

// File: rtl/jtcop_irqtimer.sv
// Vblank IRQ auto-clear timer: reloads on vblank start,
// emits one clear pulse on expiry or CPU acknowledge.
module jtcop_irqtimer
  import jtcop_pkg::*;
#(
  parameter int TOUT = TOUT_DEF
)(
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic iack,
  output logic vint_clr
);
  logic [7:0] cnt_q, cnt_d;
  logic       pulse_q, pulse_d;

  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = iack || (cnt_q == 8'd1);
    if (iack)
      cnt_d = 8'd0;
    else if (load)
      cnt_d = 8'(TOUT);
    else if (cnt_q != 8'd0)
      cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= 8'd0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign vint_clr = pulse_q;
endmodule

// File: rtl/jtcop_nexmap.sv
// CPU window region remapper with map counter and
// vblank-driven object copy / IRQ clear generation.
module jtcop_nexmap
  import jtcop_pkg::*;
#(
  parameter int MAPW   = MAPW_DEF,
  parameter int NMAP   = NMAP_DEF,
  parameter int STEP   = STEP_DEF,
  parameter int UPREG  = UPREG_DEF,
  parameter int CLRREG = CLRREG_DEF,
  parameter int TOUT   = TOUT_DEF
)(
  input  logic            clk,
  input  logic            rstn,
  input  logic            ASn,
  input  logic            RnW,
  input  logic            win_cs,
  input  logic [2:0]      A,
  input  logic            LVBL,
  input  logic            iack,
  output logic [7:0]      reg_cs,
  output logic [MAPW-1:0] mapsel,
  output logic            cnt_up,
  output logic            cnt_clr,
  output logic            vint_clr,
  output logic            obj_copy
);
  localparam logic [MAPW-1:0] LAST = MAPW'(NMAP - 1);

  logic            up_q, up_d;
  logic            clr_q, clr_d;
  logic [MAPW-1:0] premap_q, premap_d;
  logic [MAPW-1:0] mapsel_q, mapsel_d;
  logic            lvbl_q, lvbl_d;
  logic            fall_q, fall_d;
  logic            obj_q, obj_d;
  logic [2:0]      idx;
  logic            hit;

  always_comb begin
    hit     = !ASn && win_cs;
    cnt_up  = hit && RnW && (A == 3'(UPREG));
    cnt_clr = hit && !RnW && (A == 3'(CLRREG));
    up_d    = cnt_up;
    clr_d   = cnt_clr;

    premap_d = premap_q;
    if (cnt_clr && !clr_q)
      premap_d = '0;
    else if (cnt_up && !up_q)
      premap_d = (premap_q == LAST) ? '0 : premap_q + MAPW'(1);

    // map only moves between bus cycles
    mapsel_d = ASn ? premap_q : mapsel_q;

    lvbl_d = LVBL;
    fall_d = lvbl_q && !LVBL;
    obj_d  = fall_q;

    idx    = A + 3'(32'(mapsel_q) * STEP);
    reg_cs = hit ? onehot8(idx) : 8'h00;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      up_q     <= 1'b0;
      clr_q    <= 1'b0;
      premap_q <= '0;
      mapsel_q <= '0;
      lvbl_q   <= 1'b1;
      fall_q   <= 1'b0;
      obj_q    <= 1'b0;
    end else begin
      up_q     <= up_d;
      clr_q    <= clr_d;
      premap_q <= premap_d;
      mapsel_q <= mapsel_d;
      lvbl_q   <= lvbl_d;
      fall_q   <= fall_d;
      obj_q    <= obj_d;
    end
  end

  jtcop_irqtimer #(
    .TOUT (TOUT)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (fall_q),
    .iack     (iack),
    .vint_clr (vint_clr)
  );

  assign mapsel   = mapsel_q;
  assign obj_copy = obj_q;
endmodule

// File: tb/tb_jtcop_nexmap.sv
// Randomized and directed bench for jtcop_nexmap against
// an event-level reference model, three parameter sets.
module tb_jtcop_nexmap;
  logic clk = 0, rstn = 0;
  logic ASn = 1, RnW = 1, win_cs = 0, LVBL = 1, iack = 0;
  logic [2:0] A = 0;
  logic [7:0] rc [3];
  logic [1:0] ms [3];
  logic up [3], cl [3], vc [3], oc [3];

  localparam int NM [3] = '{4, 3, 4};
  localparam int ST [3] = '{1, 1, 3};
  localparam int TO [3] = '{127, 127, 20};

  jtcop_nexmap u0 (
    .clk(clk), .rstn(rstn), .ASn(ASn), .RnW(RnW),
    .win_cs(win_cs), .A(A), .LVBL(LVBL), .iack(iack),
    .reg_cs(rc[0]), .mapsel(ms[0]), .cnt_up(up[0]),
    .cnt_clr(cl[0]), .vint_clr(vc[0]), .obj_copy(oc[0]));
  jtcop_nexmap #(.NMAP(3)) u1 (
    .clk(clk), .rstn(rstn), .ASn(ASn), .RnW(RnW),
    .win_cs(win_cs), .A(A), .LVBL(LVBL), .iack(iack),
    .reg_cs(rc[1]), .mapsel(ms[1]), .cnt_up(up[1]),
    .cnt_clr(cl[1]), .vint_clr(vc[1]), .obj_copy(oc[1]));
  jtcop_nexmap #(.STEP(3), .TOUT(20)) u2 (
    .clk(clk), .rstn(rstn), .ASn(ASn), .RnW(RnW),
    .win_cs(win_cs), .A(A), .LVBL(LVBL), .iack(iack),
    .reg_cs(rc[2]), .mapsel(ms[2]), .cnt_up(up[2]),
    .cnt_clr(cl[2]), .vint_clr(vc[2]), .obj_copy(oc[2]));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state
  int premap [3], msel [3], dl [3];
  bit ve [3], oe [3];
  bit pup, pclr, plv, fprev;
  int ncyc;

  task automatic mreset();
    for (int i = 0; i < 3; i++) begin
      premap[i] = 0; msel[i] = 0; dl[i] = -1;
      ve[i] = 0; oe[i] = 0;
    end
    pup = 0; pclr = 0; plv = 1; fprev = 0;
  endtask

  task automatic drive(input bit asn, input bit rnw, input bit cs,
                       input logic [2:0] a, input bit lv, input bit ik);
    int s;
    logic [7:0] er;
    ASn = asn; RnW = rnw; win_cs = cs; A = a; LVBL = lv; iack = ik;
    #4;
    for (int i = 0; i < 3; i++) begin
      s  = (int'(a) + msel[i] * ST[i]) % 8;
      er = (!asn && cs) ? 8'(1 << s) : 8'h00;
      chk($sformatf("reg_cs%0d", i), 32'(rc[i]), 32'(er));
      chk($sformatf("mapsel%0d", i), 32'(ms[i]), 32'(msel[i]));
      chk($sformatf("vint%0d", i), 32'(vc[i]), 32'(ve[i]));
      chk($sformatf("obj%0d", i), 32'(oc[i]), 32'(oe[i]));
      chk($sformatf("cnt_up%0d", i), 32'(up[i]),
          32'(!asn && cs && rnw && a == 3'd2));
      chk($sformatf("cnt_clr%0d", i), 32'(cl[i]),
          32'(!asn && cs && !rnw && a == 3'd5));
    end
  endtask

  task automatic tick();
    bit u, c;
    int nm;
    @(posedge clk);
    u = !ASn && win_cs && RnW && A == 3'd2;
    c = !ASn && win_cs && !RnW && A == 3'd5;
    ncyc++;
    for (int i = 0; i < 3; i++) begin
      ve[i] = iack || (dl[i] == ncyc);
      oe[i] = fprev;
      nm = ASn ? premap[i] : msel[i];
      if (c && !pclr) premap[i] = 0;
      else if (u && !pup) premap[i] = (premap[i] + 1) % NM[i];
      msel[i] = nm;
      if (iack) dl[i] = -1;
      else if (fprev) dl[i] = ncyc + TO[i];
    end
    fprev = plv && !LVBL;
    plv = LVBL; pup = u; pclr = c;
    #1;
  endtask

  task automatic step(input bit asn, input bit rnw, input bit cs,
                      input logic [2:0] a, input bit lv, input bit ik);
    drive(asn, rnw, cs, a, lv, ik);
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 1, 0, 3'd0, LVBL, 0);
  endtask

  task automatic do_reset();
    #1 rstn = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_mapsel%0d", i), 32'(ms[i]), 32'd0);
      chk($sformatf("rst_vint%0d", i), 32'(vc[i]), 32'd0);
      chk($sformatf("rst_obj%0d", i), 32'(oc[i]), 32'd0);
    end
    mreset();
    ASn = 1; LVBL = 1; iack = 0; win_cs = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1;
  endtask

  int vcnt [3], vlast [3], ocnt, ofirst;

  task automatic watch(input int n, input bit fall1, input int fall2,
                       input int ik_at);
    bit lv;
    for (int i = 0; i < 3; i++) begin vcnt[i] = 0; vlast[i] = -1; end
    ocnt = 0; ofirst = -1;
    for (int k = 0; k < n; k++) begin
      lv = !((fall1 && k < 10) || (fall2 >= 0 && k >= fall2));
      drive(1, 1, 0, 3'd0, lv, k == ik_at);
      for (int i = 0; i < 3; i++)
        if (vc[i]) begin vcnt[i]++; vlast[i] = k; end
      if (oc[0]) begin
        ocnt++;
        if (ofirst < 0) ofirst = k;
      end
      tick();
    end
  endtask

  initial begin
    mreset();
    ncyc = 0;
    #3;
    chk("reset_mapsel", 32'(ms[0]), 32'd0);
    chk("reset_vint", 32'(vc[0]), 32'd0);
    chk("reset_obj", 32'(oc[0]), 32'd0);
    @(posedge clk); #1 rstn = 1;
    idle(2);

    // three count-up reads, ASn toggling
    repeat (3) begin
      step(0, 1, 1, 3'd2, 1, 0);
      idle(1);
    end
    drive(0, 1, 1, 3'd0, 1, 0);
    chk("req22_mapsel", 32'(ms[0]), 32'd3);
    chk("req22_regcs", 32'(rc[0]), 32'h08);
    chk("req23_nmap3", 32'(ms[1]), 32'd0);
    tick(); idle(1);
    drive(0, 1, 1, 3'd7, 1, 0);
    chk("req25_wrap", 32'(rc[2]), 32'h01);
    tick(); idle(1);
    step(0, 1, 1, 3'd2, 1, 0);
    idle(1);
    drive(1, 1, 0, 3'd0, 1, 0);
    chk("req23_wrap", 32'(ms[0]), 32'd0);
    tick();

    // held bus cycle keeps the map
    step(0, 1, 1, 3'd2, 1, 0);
    idle(1);
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 1, 3'd2, 1, 0);
      chk("req24_hold", 32'(ms[0]), 32'd1);
      tick();
    end
    idle(1);
    drive(1, 1, 0, 3'd0, 1, 0);
    chk("req24_after", 32'(ms[0]), 32'd2);
    tick();
    step(0, 0, 1, 3'd5, 1, 0);
    idle(1);
    drive(1, 1, 0, 3'd0, 1, 0);
    chk("req24_clear", 32'(ms[0]), 32'd0);
    tick();

    // vblank: obj copy and IRQ auto-clear, then reload
    idle(2);
    watch(200, 1, 50, -1);
    chk("req26_obj_at", 32'(ofirst), 32'd2);
    chk("req26_obj_n", 32'(ocnt), 32'd2);
    chk("req26_vint_n", 32'(vcnt[0]), 32'd1);
    chk("req26_vint_at", 32'(vlast[0]), 32'(50 + 127 + 2));
    chk("req26_t20_n", 32'(vcnt[2]), 32'd2);
    chk("req26_t20_at", 32'(vlast[2]), 32'(50 + 20 + 2));

    // acknowledge cancels auto-clear
    LVBL = 1; idle(2);
    watch(200, 1, -1, 20);
    chk("req27_iack_n", 32'(vcnt[0]), 32'd1);
    chk("req27_iack_at", 32'(vlast[0]), 32'd21);
    chk("req27_t20_n", 32'(vcnt[2]), 32'd1);
    chk("req27_t20_at", 32'(vlast[2]), 32'd21);

    // reset mid-timer, with a bus cycle in flight
    LVBL = 1; idle(2);
    step(0, 1, 1, 3'd2, 1, 0);
    idle(1);
    for (int k = 0; k < 10; k++) step(0, 1, 1, 3'd2, 0, 0);
    do_reset();
    watch(200, 0, -1, -1);
    chk("req27_rst_vint", 32'(vcnt[0]), 32'd0);
    chk("req27_rst_obj", 32'(ocnt), 32'd0);

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      bit lv;
      lv = ($urandom_range(0, 29) == 0) ? !LVBL : LVBL;
      if (k == 700) do_reset();
      step(1'($urandom % 2), 1'($urandom % 2),
           1'($urandom_range(0, 3) != 0), 3'($urandom % 8),
           lv, $urandom_range(0, 59) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
